// File: rtl/fft_butterfly_pipe_if.sv
// Request/read-data/write-back bundle between the ping-pong memory controller
// and the radix-2 butterfly datapath. The controller drives the master side.
interface fft_butterfly_pipe_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_W     = 3
);

  // AGU read request tags
  logic                         req_valid;
  logic        [ADDR_W-1:0]     req_stage;
  logic                         req_is_last;
  logic        [ADDR_W-1:0]     req_addr1;
  logic        [ADDR_W-1:0]     req_addr2;

  // RAM / twiddle ROM read data, one cycle after the request
  logic signed [DATA_WIDTH-1:0] a_re;
  logic signed [DATA_WIDTH-1:0] a_im;
  logic signed [DATA_WIDTH-1:0] b_re;
  logic signed [DATA_WIDTH-1:0] b_im;
  logic signed [DATA_WIDTH-1:0] t_re;
  logic signed [DATA_WIDTH-1:0] t_im;

  // Write-back
  logic                         out_valid;
  logic        [ADDR_W-1:0]     out_stage;
  logic                         out_is_last;
  logic        [ADDR_W-1:0]     out_addr1;
  logic        [ADDR_W-1:0]     out_addr2;
  logic signed [DATA_WIDTH-1:0] oa_re;
  logic signed [DATA_WIDTH-1:0] oa_im;
  logic signed [DATA_WIDTH-1:0] ob_re;
  logic signed [DATA_WIDTH-1:0] ob_im;

  modport master (
    output req_valid, req_stage, req_is_last, req_addr1, req_addr2,
    output a_re, a_im, b_re, b_im, t_re, t_im,
    input  out_valid, out_stage, out_is_last, out_addr1, out_addr2,
    input  oa_re, oa_im, ob_re, ob_im
  );

  modport slave (
    input  req_valid, req_stage, req_is_last, req_addr1, req_addr2,
    input  a_re, a_im, b_re, b_im, t_re, t_im,
    output out_valid, out_stage, out_is_last, out_addr1, out_addr2,
    output oa_re, oa_im, ob_re, ob_im
  );

endinterface

// File: rtl/fft_butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly: A' = A + B*W, B' = A - B*W.
// P0 aligns tags with the RAM/ROM read latency, P1 multiplies, P2 forms the
// rounded complex product, P3 adds/subtracts and scales or saturates.
// One butterfly per clock, request-to-write-back latency of four cycles.
module fft_butterfly_pipe #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N          = 8,
  parameter int unsigned SCALE      = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  fft_butterfly_pipe_if.slave bus,
  output logic                busy,
  output logic                done,
  output logic                ovf
);

  localparam int unsigned ADDR_W = $clog2(N);
  localparam int unsigned DW     = DATA_WIDTH;
  localparam int unsigned PW     = 2 * DATA_WIDTH;

  typedef struct packed {
    logic [ADDR_W-1:0] stage;
    logic              is_last;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
  } tag_t;

  // Half an LSB of the Q1.15 result, for round-half-up before the shift
  localparam logic signed [PW:0] WRound = {{(PW-DW+2){1'b0}}, 1'b1, {(DW-2){1'b0}}};
  localparam logic signed [PW:0] WMax   = {{(PW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW:0] WMin   = ~WMax;
  localparam logic signed [DW:0] SMax   = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW:0] SMin   = ~SMax;

  // Rounds a full-precision product sum back to DW bits; bit DW flags a clamp.
  function automatic logic [DW:0] fold_w(input logic signed [PW:0] sum);
    logic signed [PW:0] sh;
    sh = (sum + WRound) >>> (DW - 1);
    if (sh > WMax)      fold_w = {1'b1, WMax[DW-1:0]};
    else if (sh < WMin) fold_w = {1'b1, WMin[DW-1:0]};
    else                fold_w = {1'b0, sh[DW-1:0]};
  endfunction

  // Halves (floor) or clamps a DW+1 bit sum; bit DW flags a clamp.
  function automatic logic [DW:0] fold_s(input logic signed [DW:0] x);
    if (SCALE != 0)     fold_s = {1'b0, x[DW:1]};
    else if (x > SMax)  fold_s = {1'b1, SMax[DW-1:0]};
    else if (x < SMin)  fold_s = {1'b1, SMin[DW-1:0]};
    else                fold_s = {1'b0, x[DW-1:0]};
  endfunction

  logic                 ld0, ld1, ld2, ld3;
  logic                 p0_valid_q, p1_valid_q, p2_valid_q, p3_valid_q;
  tag_t                 tag_in;
  tag_t                 p0_tag_q, p1_tag_q, p2_tag_q, p3_tag_q;

  logic signed [PW-1:0] prod_rr, prod_ii, prod_ri, prod_ir;
  logic signed [PW-1:0] p1_rr_q, p1_ii_q, p1_ri_q, p1_ir_q;
  logic signed [DW-1:0] p1_a_re_q, p1_a_im_q;

  logic signed [PW:0]   w_re_sum, w_im_sum;
  logic        [DW:0]   w_re_f, w_im_f;
  logic signed [DW-1:0] p2_w_re_q, p2_w_im_q, p2_a_re_q, p2_a_im_q;

  logic signed [DW:0]   s_re, s_im, d_re, d_im;
  logic        [DW:0]   s_re_f, s_im_f, d_re_f, d_im_f;
  logic signed [DW-1:0] oa_re_q, oa_im_q, ob_re_q, ob_im_q;

  logic                 ovf_d, ovf_q;

  // Stage load enables; clr squashes both the valid and the data load
  always_comb begin
    ld0    = bus.req_valid & ~clr;
    ld1    = p0_valid_q & ~clr;
    ld2    = p1_valid_q & ~clr;
    ld3    = p2_valid_q & ~clr;
    tag_in = '{stage:   bus.req_stage,
               is_last: bus.req_is_last,
               addr1:   bus.req_addr1,
               addr2:   bus.req_addr2};
  end

  // Valid chain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p0_valid_q <= 1'b0;
      p1_valid_q <= 1'b0;
      p2_valid_q <= 1'b0;
      p3_valid_q <= 1'b0;
    end else begin
      p0_valid_q <= ld0;
      p1_valid_q <= ld1;
      p2_valid_q <= ld2;
      p3_valid_q <= ld3;
    end
  end

  // Inner tag/data registers; they only ever load on a valid entry
  always_ff @(posedge clk) begin
    if (ld0) p0_tag_q <= tag_in;
    if (ld1) begin
      p1_tag_q  <= p0_tag_q;
      p1_rr_q   <= prod_rr;
      p1_ii_q   <= prod_ii;
      p1_ri_q   <= prod_ri;
      p1_ir_q   <= prod_ir;
      p1_a_re_q <= bus.a_re;
      p1_a_im_q <= bus.a_im;
    end
    if (ld2) begin
      p2_tag_q  <= p1_tag_q;
      p2_w_re_q <= w_re_f[DW-1:0];
      p2_w_im_q <= w_im_f[DW-1:0];
      p2_a_re_q <= p1_a_re_q;
      p2_a_im_q <= p1_a_im_q;
    end
  end

  // P1 multipliers fed straight from the RAM/ROM read data
  always_comb begin
    prod_rr = PW'(bus.b_re) * PW'(bus.t_re);
    prod_ii = PW'(bus.b_im) * PW'(bus.t_im);
    prod_ri = PW'(bus.b_re) * PW'(bus.t_im);
    prod_ir = PW'(bus.b_im) * PW'(bus.t_re);
  end

  // P2 complex product W = B*T, rounded back to DW bits
  always_comb begin
    w_re_sum = (PW+1)'(p1_rr_q) - (PW+1)'(p1_ii_q);
    w_im_sum = (PW+1)'(p1_ri_q) + (PW+1)'(p1_ir_q);
    w_re_f   = fold_w(w_re_sum);
    w_im_f   = fold_w(w_im_sum);
  end

  // P3 butterfly sums at one bit of headroom, then scale or saturate
  always_comb begin
    s_re   = (DW+1)'(p2_a_re_q) + (DW+1)'(p2_w_re_q);
    s_im   = (DW+1)'(p2_a_im_q) + (DW+1)'(p2_w_im_q);
    d_re   = (DW+1)'(p2_a_re_q) - (DW+1)'(p2_w_re_q);
    d_im   = (DW+1)'(p2_a_im_q) - (DW+1)'(p2_w_im_q);
    s_re_f = fold_s(s_re);
    s_im_f = fold_s(s_im);
    d_re_f = fold_s(d_re);
    d_im_f = fold_s(d_im);
  end

  // Write-back registers, zeroed by reset but untouched by clr
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p3_tag_q <= '0;
      oa_re_q  <= '0;
      oa_im_q  <= '0;
      ob_re_q  <= '0;
      ob_im_q  <= '0;
    end else if (ld3) begin
      p3_tag_q <= p2_tag_q;
      oa_re_q  <= s_re_f[DW-1:0];
      oa_im_q  <= s_im_f[DW-1:0];
      ob_re_q  <= d_re_f[DW-1:0];
      ob_im_q  <= d_im_f[DW-1:0];
    end
  end

  // Sticky overflow next-state: any clamp on a valid entry, cleared by clr
  always_comb begin
    ovf_d = ovf_q;
    if (ld2 && (w_re_f[DW] || w_im_f[DW])) ovf_d = 1'b1;
    if (ld3 && (s_re_f[DW] || s_im_f[DW] || d_re_f[DW] || d_im_f[DW])) ovf_d = 1'b1;
    if (clr) ovf_d = 1'b0;
  end

  // Sticky overflow register
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign bus.out_valid   = p3_valid_q;
  assign bus.out_stage   = p3_tag_q.stage;
  assign bus.out_is_last = p3_tag_q.is_last;
  assign bus.out_addr1   = p3_tag_q.addr1;
  assign bus.out_addr2   = p3_tag_q.addr2;
  assign bus.oa_re       = oa_re_q;
  assign bus.oa_im       = oa_im_q;
  assign bus.ob_re       = ob_re_q;
  assign bus.ob_im       = ob_im_q;

  assign busy = p0_valid_q | p1_valid_q | p2_valid_q | p3_valid_q;
  assign done = p3_valid_q & p3_tag_q.is_last;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Bench for fft_butterfly_pipe: one scaling and one saturating instance share
// the same stimulus; a queue-based reference model predicts every output.
module tb_fft_butterfly_pipe;

  localparam int DW = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clr;
  logic busy1, done1, ovf1, busy0, done0, ovf0;

  fft_butterfly_pipe_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) ifs1 ();
  fft_butterfly_pipe_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) ifs0 ();

  fft_butterfly_pipe #(.DATA_WIDTH(DW), .N(8), .SCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifs1.slave),
    .busy(busy1), .done(done1), .ovf(ovf1)
  );

  fft_butterfly_pipe #(.DATA_WIDTH(DW), .N(8), .SCALE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifs0.slave),
    .busy(busy0), .done(done0), .ovf(ovf0)
  );

  typedef struct {
    int due, stage, last, a1, a2;
    int ar1, ai1, br1, bi1;
    int ar0, ai0, br0, bi0;
    bit wsat, ssat0;
  } exp_t;

  typedef struct {
    int stage, last, a1, a2, ar, ai, br, bi;
  } out_t;

  exp_t q[$];
  out_t hold1, hold0;
  bit   ovf1_m, ovf0_m;
  int   slot, checks, errors, s0;
  bit   pend;
  int   pd[6];

  function automatic int clampw(input longint x, output bit hit);
    longint mx = (longint'(1) << (DW - 1)) - 1;
    hit = 1'b0;
    if (x > mx) begin
      hit = 1'b1;
      return int'(mx);
    end
    if (x < -mx - 1) begin
      hit = 1'b1;
      return int'(-mx - 1);
    end
    return int'(x);
  endfunction

  // Reference butterfly in plain integer arithmetic
  function automatic void butterfly(input int ar, ai, br, bi, tr, ti, output exp_t e);
    longint half = longint'(1) << (DW - 2);
    longint wr_f = longint'(br) * tr - longint'(bi) * ti;
    longint wi_f = longint'(br) * ti + longint'(bi) * tr;
    bit h1, h2, h3, h4, h5, h6;
    int wr, wi;
    wr = clampw((wr_f + half) >>> (DW - 1), h1);
    wi = clampw((wi_f + half) >>> (DW - 1), h2);
    e.wsat = h1 | h2;
    e.ar1 = int'((longint'(ar) + wr) >>> 1);
    e.ai1 = int'((longint'(ai) + wi) >>> 1);
    e.br1 = int'((longint'(ar) - wr) >>> 1);
    e.bi1 = int'((longint'(ai) - wi) >>> 1);
    e.ar0 = clampw(longint'(ar) + wr, h3);
    e.ai0 = clampw(longint'(ai) + wi, h4);
    e.br0 = clampw(longint'(ar) - wr, h5);
    e.bi0 = clampw(longint'(ai) - wi, h6);
    e.ssat0 = h3 | h4 | h5 | h6;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  function automatic int rnd_tw();
    int v = rnd16();
    if (v == -32768) v = -32767;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string who, input logic ov, dn, bz, of,
                            input logic [AW-1:0] st, input logic lst,
                            input logic [AW-1:0] a1, a2,
                            input logic signed [DW-1:0] ar, ai, br, bi,
                            input bit ev, ebusy, eovf, input out_t h);
    check({who, "_out_valid"}, 32'(ov), 32'(ev));
    check({who, "_done"}, 32'(dn), 32'(ev && (h.last != 0)));
    check({who, "_busy"}, 32'(bz), 32'(ebusy));
    check({who, "_ovf"}, 32'(of), 32'(eovf));
    check({who, "_out_stage"}, 32'(st), h.stage);
    check({who, "_out_is_last"}, 32'(lst), h.last);
    check({who, "_out_addr1"}, 32'(a1), h.a1);
    check({who, "_out_addr2"}, 32'(a2), h.a2);
    check({who, "_oa_re"}, 32'(ar), h.ar);
    check({who, "_oa_im"}, 32'(ai), h.ai);
    check({who, "_ob_re"}, 32'(br), h.br);
    check({who, "_ob_im"}, 32'(bi), h.bi);
  endtask

  task automatic drive_data(input int ar, ai, br, bi, tr, ti);
    ifs1.a_re = DW'(ar); ifs1.a_im = DW'(ai); ifs1.b_re = DW'(br);
    ifs1.b_im = DW'(bi); ifs1.t_re = DW'(tr); ifs1.t_im = DW'(ti);
    ifs0.a_re = DW'(ar); ifs0.a_im = DW'(ai); ifs0.b_re = DW'(br);
    ifs0.b_im = DW'(bi); ifs0.t_re = DW'(tr); ifs0.t_im = DW'(ti);
  endtask

  task automatic drive_req(input bit v, input int st, lst, a1, a2);
    ifs1.req_valid = v; ifs1.req_stage = AW'(st); ifs1.req_is_last = lst[0];
    ifs1.req_addr1 = AW'(a1); ifs1.req_addr2 = AW'(a2);
    ifs0.req_valid = v; ifs0.req_stage = AW'(st); ifs0.req_is_last = lst[0];
    ifs0.req_addr1 = AW'(a1); ifs0.req_addr2 = AW'(a2);
  endtask

  // Present a request this cycle; its data follows on the next cycle
  task automatic issue(input int st, lst, a1, a2, ar, ai, br, bi, tr, ti);
    exp_t e;
    butterfly(ar, ai, br, bi, tr, ti, e);
    e.due = slot + 4; e.stage = st; e.last = lst; e.a1 = a1; e.a2 = a2;
    q.push_back(e);
    drive_req(1'b1, st, lst, a1, a2);
    pend = 1'b1;
    pd = '{ar, ai, br, bi, tr, ti};
  endtask

  task automatic issue_rand(input int lst);
    issue(int'($urandom_range(7)), lst, int'($urandom_range(7)), int'($urandom_range(7)),
          rnd16(), rnd16(), rnd16(), rnd16(), rnd_tw(), rnd_tw());
  endtask

  // Advance one clock, update the model for what the edge sampled, compare
  task automatic tick();
    exp_t f;
    bit   have, busy_m;
    @(posedge clk);
    #1;
    slot++;
    if (!rst_n) begin
      q.delete();
      ovf1_m = 1'b0; ovf0_m = 1'b0;
      hold1 = '{default: 0}; hold0 = '{default: 0};
    end else if (clr) begin
      q.delete();
      ovf1_m = 1'b0; ovf0_m = 1'b0;
    end
    foreach (q[i]) if (q[i].wsat && q[i].due == slot + 1) begin
      ovf1_m = 1'b1; ovf0_m = 1'b1;
    end
    busy_m = (q.size() > 0) && (q[0].due - 3 <= slot);
    have   = (q.size() > 0) && (q[0].due == slot);
    if (have) begin
      f = q.pop_front();
      if (f.ssat0) ovf0_m = 1'b1;
      hold1 = '{f.stage, f.last, f.a1, f.a2, f.ar1, f.ai1, f.br1, f.bi1};
      hold0 = '{f.stage, f.last, f.a1, f.a2, f.ar0, f.ai0, f.br0, f.bi0};
    end
    check_outs("s1", ifs1.out_valid, done1, busy1, ovf1, ifs1.out_stage, ifs1.out_is_last,
               ifs1.out_addr1, ifs1.out_addr2, ifs1.oa_re, ifs1.oa_im, ifs1.ob_re, ifs1.ob_im,
               have, busy_m, ovf1_m, hold1);
    check_outs("s0", ifs0.out_valid, done0, busy0, ovf0, ifs0.out_stage, ifs0.out_is_last,
               ifs0.out_addr1, ifs0.out_addr2, ifs0.oa_re, ifs0.oa_im, ifs0.ob_re, ifs0.ob_im,
               have, busy_m, ovf0_m, hold0);
    rst_n = 1'b1;
    clr   = 1'b0;
    drive_req(1'b0, 0, 0, 0, 0);
    if (pend) drive_data(pd[0], pd[1], pd[2], pd[3], pd[4], pd[5]);
    else      drive_data(rnd16(), rnd16(), rnd16(), rnd16(), rnd_tw(), rnd_tw());
    pend = 1'b0;
  endtask

  initial begin
    slot = 0; checks = 0; errors = 0; pend = 1'b0;
    ovf1_m = 1'b0; ovf0_m = 1'b0;
    hold1 = '{default: 0}; hold0 = '{default: 0};
    rst_n = 1'b0; clr = 1'b0;
    drive_req(1'b0, 0, 0, 0, 0);
    drive_data(0, 0, 0, 0, 0, 0);

    // Reset
    tick(); rst_n = 1'b0; tick(); tick();
    check("rst_out_valid", 32'(ifs1.out_valid), 0);
    check("rst_oa_re", 32'(ifs1.oa_re), 0);

    // Twiddle +1, scaled
    issue(1, 0, 2, 6, 'h1000, 0, 'h0800, 0, 'h7FFF, 0);
    repeat (4) tick();
    check("tw1_out_valid", 32'(ifs1.out_valid), 1);
    check("tw1_oa_re", 32'(ifs1.oa_re), 'h0C00);
    check("tw1_ob_re", 32'(ifs1.ob_re), 'h0400);
    check("tw1_out_addr2", 32'(ifs1.out_addr2), 6);
    tick();

    // Twiddle -j, scaled
    issue(2, 0, 3, 7, 0, 0, 'h0800, 0, 0, -32767);
    repeat (4) tick();
    check("twj_oa_im", 32'(ifs1.oa_im), -1024);
    check("twj_ob_im", 32'(ifs1.ob_im), 'h0400);
    tick();

    // Saturation on the unscaled instance, sticky until clr
    issue(0, 0, 0, 1, 'h7000, 0, 'h7000, 0, 'h7FFF, 0);
    repeat (4) tick();
    check("sat_oa_re", 32'(ifs0.oa_re), 'h7FFF);
    check("sat_ob_re", 32'(ifs0.ob_re), 1);
    check("sat_ovf", 32'(ovf0), 1);
    repeat (3) tick();
    check("sat_ovf_sticky", 32'(ovf0), 1);
    clr = 1'b1;
    tick();
    check("sat_ovf_clr", 32'(ovf0), 0);
    tick();

    // Streaming with one bubble before the last butterfly
    s0 = slot;
    issue(1, 0, 0, 4, rnd16(), rnd16(), rnd16(), rnd16(), rnd_tw(), rnd_tw()); tick();
    issue(1, 0, 2, 6, rnd16(), rnd16(), rnd16(), rnd16(), rnd_tw(), rnd_tw()); tick();
    issue(1, 0, 1, 5, rnd16(), rnd16(), rnd16(), rnd16(), rnd_tw(), rnd_tw()); tick();
    issue(1, 0, 3, 7, rnd16(), rnd16(), rnd16(), rnd16(), rnd_tw(), rnd_tw()); tick();
    tick();
    issue(2, 1, 3, 7, rnd16(), rnd16(), rnd16(), rnd16(), rnd_tw(), rnd_tw());
    while (slot < s0 + 8) tick();
    check("stream_gap_valid", 32'(ifs1.out_valid), 0);
    tick();
    check("stream_done", 32'(done1), 1);
    check("stream_is_last", 32'(ifs1.out_is_last), 1);
    repeat (2) tick();

    // Flush with three in flight; the third request rides with clr
    issue_rand(0); tick();
    issue_rand(0); tick();
    issue_rand(0); clr = 1'b1; tick();
    check("flush_busy", 32'(busy1), 0);
    check("flush_ovf", 32'(ovf0), 0);
    repeat (5) tick();

    // Reset mid-stream, then a fresh request
    issue_rand(0); tick();
    issue_rand(1); tick();
    rst_n = 1'b0; tick();
    check("midrst_busy", 32'(busy1), 0);
    check("midrst_oa_re", 32'(ifs1.oa_re), 0);
    issue(3, 0, 5, 1, 'h0100, 'h0200, 'h0300, 'h0400, 'h7FFF, 0);
    repeat (4) tick();
    check("midrst_fresh_valid", 32'(ifs1.out_valid), 1);
    tick();

    // Random traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(39) == 0) clr = 1'b1;
      if ($urandom_range(3) != 0) issue_rand(($urandom_range(7) == 0) ? 1 : 0);
      tick();
    end
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_butterfly_pipe.md
# fft_butterfly_pipe

Pipelined radix-2 decimation-in-time butterfly datapath for the in-place FFT engine. It sits between the ping-pong memory controller's read ports and its write ports. It takes the AGU read request tags (addresses, stage, last flag) and the A/B/twiddle words the RAMs and twiddle ROM return one cycle later. It produces the write-back pair A' = A + B·W and B' = A − B·W with matching write addresses and stage info, one butterfly per clock with no backpressure.

## Interface
- DATA_WIDTH, 16: bits per real/imag component, signed two's complement; twiddles are Q1.15.
- N, 8: FFT size, power of two ≥ 4; ADDR_W = $clog2(N).
- SCALE, 1: 1 = divide every butterfly output by 2 (per-stage scaling); 0 = saturate, no scaling.
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- clr  in  1  synchronous flush: drops all in-flight butterflies and clears ovf.
- req_valid  in  1  AGU issued a read this cycle (already gated by stall).
- req_stage  in  ADDR_W  stage of this request.
- req_is_last  in  1  final butterfly of the final stage.
- req_addr1, req_addr2  in  ADDR_W  read addresses, reused as write addresses.
- a_re, a_im, b_re, b_im  in  DATA_WIDTH each  RAM read data, valid the cycle after req.
- t_re, t_im  in  DATA_WIDTH each  twiddle ROM data, valid the cycle after req.
- out_valid  out  1  write-back valid (memory write enable).
- out_stage  out  ADDR_W  stage of the write-back, used by the controller's stall compare.
- out_is_last  out  1  tag copy.
- out_addr1, out_addr2  out  ADDR_W  write addresses.
- oa_re, oa_im, ob_re, ob_im  out  DATA_WIDTH each  A' and B'.
- busy  out  1  any valid in flight in P0..P3.
- done  out  1  out_valid & out_is_last.
- ovf  out  1  sticky saturation flag.

## Operation
- Pipeline registers, each with a valid bit and a full tag copy (stage, is_last, addr1, addr2):
  - P0: tag register only; aligns tags with the 1-cycle RAM/ROM read latency.
  - P1: four signed products br·tr, bi·ti, br·ti, bi·tr (2·DATA_WIDTH bits each); A delayed.
  - P2: complex product W. W.re = br·tr − bi·ti and W.im = br·ti + bi·tr, summed at 2·DATA_WIDTH+1 bits. Add 2^(DATA_WIDTH−2) (round half up), arithmetic shift right DATA_WIDTH−1, saturate to DATA_WIDTH. A delayed.
  - P3: sums s = A + W and d = A − W at DATA_WIDTH+1 bits.
    - SCALE=1: output arithmetic >>1, truncated toward −inf; never saturates.
    - SCALE=0: saturate to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
    - Registered into the oa/ob outputs.
- ovf sets when any saturation fires in P2 or P3 on a valid entry. It holds until rst_n or clr.
- Data registers load only when their stage's valid-in is 1; otherwise they hold.
- No backpressure: the controller stalls the AGU while out_valid and out_stage ≠ req_stage. The block only needs to report out_stage/out_valid correctly; bubbles pass through unchanged.
- Twiddle 0x7FFF represents +1 (≈1−2^−15). The twiddle ROM never holds −1.
- clr or reset: all valid bits and ovf cleared on the next edge; data registers unchanged.
- clr asserted alongside req_valid: that request is dropped.

## Timing
- Latency: req_valid at cycle r → out_valid at cycle r+4. Throughput is 1 butterfly/cycle.
- done pulses for exactly the single cycle out_valid carries is_last.
- busy is 1 while any of P0..P3 is valid, including the out_valid cycle. It is 0 the cycle after the last valid leaves P3.
- Reset values: out_valid 0, done 0, busy 0, ovf 0, out_stage 0, out_is_last 0, out_addr1/2 0, oa/ob 0.
- Tags emerge in the same order they entered; no reordering.

## Test plan
- Twiddle +1, SCALE=1: A=(0x1000,0), B=(0x0800,0), T=(0x7FFF,0) at r+1 → at r+4: oa=(0x0C00,0), ob=(0x0400,0), out_addr/stage equal the req values.
- Twiddle −j, SCALE=1: A=0, B=(0x0800,0), T=(0,0x8001) → W=(0,0xF800); oa=(0,0xFC00), ob=(0,0x0400).
- Saturation, SCALE=0: A=B=(0x7000,0), T=(0x7FFF,0) → W.re=0x6FFF; oa.re=0x7FFF, ob.re=0x0001, ovf=1 and stays 1 until clr.
- Streaming: 4 back-to-back requests with addr pairs (0,4),(2,6),(1,5),(3,7), then one bubble, then is_last request → out_valid high r+4..r+7, low r+8, high r+9 with done=1 and out_is_last=1; addresses in order.
- Flush: 3 requests in flight, clr pulse → no out_valid afterwards, busy=0 next cycle, ovf=0.
- Reset: rst_n low for 1 cycle mid-stream → every output at its reset value the next cycle; a fresh request afterwards yields correct out_valid at +4.
